// File: rtl/strength_pkg.sv
// Shared types and the strength resolution rule for the multi-driver net tracker.
// Strength codes and the 4-state encoding match IEEE 1800 drive strengths.
package strength_pkg;

  typedef enum logic [2:0] {
    ST_HIGHZ  = 3'd0,
    ST_SMALL  = 3'd1,
    ST_MEDIUM = 3'd2,
    ST_WEAK   = 3'd3,
    ST_LARGE  = 3'd4,
    ST_PULL   = 3'd5,
    ST_STRONG = 3'd6,
    ST_SUPPLY = 3'd7
  } strength_e;

  typedef enum logic [1:0] {
    L4_0 = 2'b00,
    L4_1 = 2'b01,
    L4_Z = 2'b10,
    L4_X = 2'b11
  } logic4_e;

  localparam int STAMP_W_DEF = 16;
  localparam int EV_W        = 2 + STAMP_W_DEF;

  function automatic logic4_e resolve(input strength_e max0, input strength_e max1);
    logic4_e r;
    if (max0 == ST_HIGHZ && max1 == ST_HIGHZ) r = L4_Z;
    else if (max1 > max0)                     r = L4_1;
    else if (max0 > max1)                     r = L4_0;
    else                                      r = L4_X;
    return r;
  endfunction

endpackage

// File: rtl/strength_event_fifo.sv
// Synchronous FIFO for time-stamped change events; pointers carry an extra wrap bit
// so full and empty are distinguished without a counter.
module strength_event_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is taken.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/strength_resolve_tracker.sv
// Resolves N strength-annotated drivers onto one 4-state net through a two-stage
// pipeline and logs every change of the resolved value with a cycle stamp.
module strength_resolve_tracker
  import strength_pkg::*;
#(
  parameter int N_DRV      = 4,
  parameter int STAMP_W    = STAMP_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N_DRV-1:0]     drv_val,
  input  logic [3*N_DRV-1:0]   drv_s0,
  input  logic [3*N_DRV-1:0]   drv_s1,
  output logic                 res_valid,
  output logic [1:0]           res,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [2+STAMP_W-1:0] ev_data,
  output logic                 ovf,
  input  logic                 clear_ovf
);

  localparam int EVW = 2 + STAMP_W;

  strength_e          max0_q, max0_d, max1_q, max1_d;
  logic               v1_q, v1_d;
  logic4_e            res_q, res_d;
  logic               rv_q, rv_d;
  logic4_e            last_q, last_d;
  logic               first_q, first_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               ovf_q, ovf_d;

  logic               push, pop, drop, fifo_full, fifo_empty;
  logic [EVW-1:0]     push_data;

  always_comb begin
    strength_e s;
    max0_d = ST_HIGHZ;
    max1_d = ST_HIGHZ;
    s      = ST_HIGHZ;
    for (int i = 0; i < N_DRV; i++) begin
      if (drv_val[i]) begin
        s = strength_e'(drv_s1[3*i +: 3]);
        if (s > max1_d) max1_d = s;
      end else begin
        s = strength_e'(drv_s0[3*i +: 3]);
        if (s > max0_d) max0_d = s;
      end
    end
    v1_d = in_valid;
  end

  always_comb begin
    rv_d    = v1_q;
    res_d   = v1_q ? resolve(max0_q, max1_q) : res_q;
    stamp_d = stamp_q + 1'b1;
  end

  // Change detect runs on the stage-2 output; the first resolution after reset
  // always logs even when it equals the reset value of last_res.
  always_comb begin
    push      = rv_q && (first_q || (res_q != last_q));
    push_data = {res_q, stamp_q};
    last_d    = rv_q ? res_q : last_q;
    first_d   = first_q && !rv_q;
    pop       = ev_valid && ev_ready;
    drop      = push && fifo_full && !pop;
    ovf_d     = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max0_q  <= ST_HIGHZ;
      max1_q  <= ST_HIGHZ;
      v1_q    <= 1'b0;
      res_q   <= L4_Z;
      rv_q    <= 1'b0;
      last_q  <= L4_Z;
      first_q <= 1'b1;
      stamp_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      max0_q  <= max0_d;
      max1_q  <= max1_d;
      v1_q    <= v1_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      last_q  <= last_d;
      first_q <= first_d;
      stamp_q <= stamp_d;
      ovf_q   <= ovf_d;
    end
  end

  strength_event_fifo #(
    .W     (EVW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (ev_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid  = !fifo_empty;
  assign res_valid = rv_q;
  assign res       = res_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_strength_resolve_tracker.sv
// Bench for strength_resolve_tracker: directed and random driver vectors checked
// against a level-scan strength model and an event-queue scoreboard.
module tb_strength_resolve_tracker;

  localparam int N     = 4;
  localparam int SW    = 4;
  localparam int DEPTH = 4;
  localparam int EW    = 2 + SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [N-1:0]  drv_val = '0;
  logic [3*N-1:0] drv_s0 = '0;
  logic [3*N-1:0] drv_s1 = '0;
  logic          res_valid;
  logic [1:0]    res;
  logic          ev_valid;
  logic          ev_ready = 1'b0;
  logic [EW-1:0] ev_data;
  logic          ovf;
  logic          clear_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [EW-1:0] exp_q[$];
  logic          m_s1_v, m_s2_v, m_first, m_ovf;
  logic [1:0]    m_s1_r, m_res, m_last;
  logic [SW-1:0] m_stamp;

  strength_resolve_tracker #(
    .N_DRV      (N),
    .STAMP_W    (SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .drv_val   (drv_val),
    .drv_s0    (drv_s0),
    .drv_s1    (drv_s1),
    .res_valid (res_valid),
    .res       (res),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_data   (ev_data),
    .ovf       (ovf),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scan strength levels from supply downward; the first level driven decides.
  function automatic logic [1:0] ref_resolve(input logic [N-1:0] v,
                                             input logic [3*N-1:0] s0,
                                             input logic [3*N-1:0] s1);
    logic hit0, hit1;
    for (int lvl = 7; lvl >= 1; lvl--) begin
      hit0 = 1'b0;
      hit1 = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (v[i]  && s1[3*i +: 3] == lvl[2:0]) hit1 = 1'b1;
        if (!v[i] && s0[3*i +: 3] == lvl[2:0]) hit0 = 1'b1;
      end
      if (hit0 && hit1) return 2'b11;
      if (hit1) return 2'b01;
      if (hit0) return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic logic [3*N-1:0] s3(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] c, input logic [2:0] d);
    return {d, c, b, a};
  endfunction

  task automatic model_reset();
    m_s1_v  = 1'b0;
    m_s2_v  = 1'b0;
    m_s1_r  = 2'b10;
    m_res   = 2'b10;
    m_last  = 2'b10;
    m_first = 1'b1;
    m_ovf   = 1'b0;
    m_stamp = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({pfx, "_res"},       32'(res),       32'd2);
    chk({pfx, "_ev_valid"},  32'(ev_valid),  32'd0);
    chk({pfx, "_ev_data"},   32'(ev_data),   32'd0);
    chk({pfx, "_ovf"},       32'(ovf),       32'd0);
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [N-1:0] val,
                       input logic [3*N-1:0] s0, input logic [3*N-1:0] s1,
                       input logic rdy, input logic clr);
    logic          push, pop, drop;
    logic [EW-1:0] ev;
    in_valid  = v;
    drv_val   = val;
    drv_s0    = s0;
    drv_s1    = s1;
    ev_ready  = rdy;
    clear_ovf = clr;
    chk("res_valid", 32'(res_valid), 32'(m_s2_v));
    chk("res",       32'(res),       32'(m_res));
    chk("ev_valid",  32'(ev_valid),  32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("ev_data", 32'(ev_data), 32'(exp_q[0]));
    chk("ovf",       32'(ovf),       32'(m_ovf));
    @(posedge clk);
    push = m_s2_v && (m_first || m_res != m_last);
    ev   = {m_res, m_stamp};
    if (m_s2_v) begin
      m_last  = m_res;
      m_first = 1'b0;
    end
    pop = rdy && (exp_q.size() > 0);
    if (pop) void'(exp_q.pop_front());
    drop = 1'b0;
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(ev);
      else drop = 1'b1;
    end
    m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    if (m_s1_v) m_res = m_s1_r;
    m_s2_v  = m_s1_v;
    m_s1_v  = v;
    m_s1_r  = ref_resolve(val, s0, s1);
    m_stamp = m_stamp + 1'b1;
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  task automatic level(input logic b, input logic rdy);
    cycle(1'b1, {N{b}}, s3(6, 6, 6, 6), s3(6, 6, 6, 6), rdy, 1'b0);
  endtask

  initial begin
    logic [N-1:0]   rv;
    logic [3*N-1:0] rs0, rs1;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    // weak 0 / highz 1 on every driver resolves to z; first event carries stamp 2
    cycle(1'b1, 4'hF, s3(3, 3, 3, 3), s3(0, 0, 0, 0), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("first_ev_valid", 32'(ev_valid), 32'd1);
    chk("first_ev_data",  32'(ev_data),  32'h22);

    // strong1 vs pull0, strong1 vs strong0, all highz, supply0 vs strong1
    cycle(1'b1, 4'b0001, s3(0, 5, 0, 0), s3(6, 0, 0, 0), 1'b1, 1'b0);
    cycle(1'b1, 4'b0001, s3(0, 6, 0, 0), s3(6, 0, 0, 0), 1'b1, 1'b0);
    cycle(1'b1, 4'b0101, s3(0, 0, 0, 0), s3(0, 0, 0, 0), 1'b1, 1'b0);
    cycle(1'b1, 4'b0010, s3(7, 0, 0, 0), s3(0, 6, 0, 0), 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // constant stream, then toggling through a stamp wrap
    repeat (6) level(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) level(i[0], 1'b1);
    repeat (4) idle(1'b1);

    // overflow with consumer stalled, drain, then clear the sticky flag
    for (int i = 0; i < 6; i++) level(i[0], 1'b0);
    repeat (3) idle(1'b0);
    repeat (6) idle(1'b1);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b1);
    idle(1'b1);

    // fill, then push and pop together while full
    for (int i = 0; i < 4; i++) level(~i[0], 1'b0);
    repeat (2) idle(1'b0);
    for (int i = 0; i < 6; i++) level(~i[0], 1'b1);
    repeat (8) idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rv  = N'($urandom_range(0, (1 << N) - 1));
      rs0 = 12'($urandom_range(0, 4095));
      rs1 = 12'($urandom_range(0, 4095));
      cycle(1'($urandom_range(0, 3) != 0), rv, rs0, rs1,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // reset in the middle of traffic with events queued
    for (int i = 0; i < 8; i++) level(i[0], 1'b0);
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    cycle(1'b1, 4'h0, s3(6, 6, 6, 6), s3(0, 0, 0, 0), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("post_rst_ev_valid", 32'(ev_valid), 32'd1);
    chk("post_rst_ev_data",  32'(ev_data),  32'h02);
    repeat (3) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
